// File: rtl/coloring_pkg.sv
// Shared definitions for the coloring generator: color codes, FSM encoding,
// history reset value, LFSR taps and the color legality rule.
package coloring_pkg;

    localparam logic [1:0] C0 = 2'b00;
    localparam logic [1:0] C1 = 2'b01;
    localparam logic [1:0] C2 = 2'b10;
    localparam logic [1:0] C3 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] HIST_RST  = 4'b1111;
    // Feedback taps l[7], l[5], l[4], l[3]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // A color is illegal if it would be the third identical color in a row,
    // or if it would sit next to its forbidden partner (00 <-> 01).
    function automatic logic legal(input logic [3:0] hist, input logic [1:0] c);
        logic w_triple;
        logic w_adjacent;
        w_triple   = (hist[3:2] == hist[1:0]) && (hist[1:0] == c);
        w_adjacent = ({hist[1:0], c} == {C0, C1}) || ({hist[1:0], c} == {C1, C0});
        return !(w_triple || w_adjacent);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/coloring_pick.sv
// Combinational color picker: returns the first legal color found by
// rotating upward from the candidate (cand, cand+1, cand+2, cand+3 mod 4).
module coloring_pick
    import coloring_pkg::*;
(
    input  logic [3:0] hist,
    input  logic [1:0] cand,
    output logic [1:0] color
);

    logic [1:0] w_try;
    logic       w_found;

    always_comb begin
        color   = cand;
        w_found = 1'b0;
        w_try   = cand;
        for (int i = 0; i < 4; i++) begin
            w_try = cand + 2'(i);
            if (!w_found && legal(hist, w_try)) begin
                color   = w_try;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coloring_gen.sv
// Legal-color stream source: emits len colors per run over valid/ready,
// choosing each color from a seeded LFSR and the two-color history.
module coloring_gen
    import coloring_pkg::*;
#(
    parameter int         LEN_W    = 8,
    parameter logic [7:0] SEED_DEF = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic [LEN_W-1:0] len,
    input  logic             ready,
    output logic             valid,
    output logic [1:0]       color,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: a color transfers on any rising edge where valid && ready.
    // While valid is high and ready is low, color and all internal state hold.

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_hist, w_hist_nxt;
    logic [7:0]       r_lfsr, w_lfsr_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_valid, w_valid_nxt;
    logic [1:0]       r_color, w_color_nxt;

    logic [7:0]       w_seed_eff;
    logic [7:0]       w_lfsr_step;
    logic [3:0]       w_hist_shift;
    logic [3:0]       w_pick_hist;
    logic [1:0]       w_pick_cand;
    logic [1:0]       w_pick;
    logic             w_accept;

    assign w_seed_eff   = (seed == 8'h00) ? SEED_DEF : seed;
    assign w_lfsr_step  = lfsr_step(r_lfsr);
    assign w_hist_shift = {r_hist[1:0], r_color};
    assign w_accept     = r_valid && ready;

    // One picker serves both the first color (from the seed) and the
    // following ones (from the post-transfer history and stepped LFSR).
    assign w_pick_hist  = (r_state == S_IDLE) ? r_hist : w_hist_shift;
    assign w_pick_cand  = (r_state == S_IDLE) ? w_seed_eff[1:0] : w_lfsr_step[1:0];

    coloring_pick u_pick (
        .hist  (w_pick_hist),
        .cand  (w_pick_cand),
        .color (w_pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hist  <= HIST_RST;
            r_lfsr  <= SEED_DEF;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_color <= C0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_color <= w_color_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_color_nxt = r_color;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_lfsr_nxt  = w_seed_eff;
                        w_cnt_nxt   = len;
                        w_color_nxt = w_pick;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    w_hist_nxt = w_hist_shift;
                    w_lfsr_nxt = w_lfsr_step;
                    if (r_cnt == LEN_W'(1)) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt - LEN_W'(1);
                        w_color_nxt = w_pick;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign valid     = r_valid;
    assign color     = r_color;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_coloring_gen.sv
// Directed bench for coloring_gen: a table of runs with hand-computed color
// sequences, plus reset-mid-run and long legal-stream sequences.
module tb_coloring_gen;
    import coloring_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [7:0] len;
    logic       ready;
    logic       valid;
    logic [1:0] color;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    coloring_gen #(.LEN_W(8), .SEED_DEF(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .len       (len),
        .ready     (ready),
        .valid     (valid),
        .color     (color),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Launch a run, consume colors into got_q, and check the done/busy tail.
    task automatic do_run(input logic [7:0] s, input logic [7:0] l, input int stall,
                          input bit pulse_start);
        int         cyc;
        int         stall_left;
        bit         first;
        logic [1:0] held;
        got_q.delete();
        stall_left = stall;
        first      = 1'b1;
        held       = 2'b00;
        cyc        = 0;
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        len   = l;
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (first) begin
                start = 1'b0;
                chk("busy_after_start", 32'(busy), 32'd1);
            end
            if (done) begin
                start = 1'b0;
                chk("valid_low_at_done", 32'(valid), 32'd0);
                chk("busy_at_done", 32'(busy), 32'd1);
                break;
            end
            if (valid) begin
                if (stall_left > 0) begin
                    ready = 1'b0;
                    if (stall_left == stall) held = color;
                    else chk("stall_hold", 32'(color), 32'(held));
                    stall_left--;
                end else begin
                    ready = 1'b1;
                    got_q.push_back(color);
                end
            end
            if (pulse_start) start = 1'($urandom_range(0, 1));
            first = 1'b0;
            cyc++;
            if (cyc > 1000) begin
                chk("run_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        ready = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] seed;
        logic [7:0] len;
        int         stall;
        int         n;
        logic [1:0] c[4];
    } vec_t;

    vec_t vecs[7];
    logic [3:0] h;
    logic [1:0] cc;
    bit         ok;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        seed  = 8'h00;
        len   = 8'h00;
        ready = 1'b1;

        // Hand-computed: hist persists across runs unless rst is set.
        vecs[0] = '{rst: 1'b1, seed: 8'h00, len: 8'd3, stall: 0, n: 3, c: '{2'b01, 2'b10, 2'b01, 2'b00}};
        vecs[1] = '{rst: 1'b1, seed: 8'h03, len: 8'd1, stall: 0, n: 1, c: '{2'b00, 2'b00, 2'b00, 2'b00}};
        vecs[2] = '{rst: 1'b0, seed: 8'h00, len: 8'd2, stall: 0, n: 2, c: '{2'b10, 2'b10, 2'b00, 2'b00}};
        vecs[3] = '{rst: 1'b0, seed: 8'h02, len: 8'd2, stall: 0, n: 2, c: '{2'b11, 2'b00, 2'b00, 2'b00}};
        vecs[4] = '{rst: 1'b1, seed: 8'h01, len: 8'd4, stall: 5, n: 4, c: '{2'b01, 2'b10, 2'b00, 2'b00}};
        vecs[5] = '{rst: 1'b0, seed: 8'h00, len: 8'd0, stall: 0, n: 0, c: '{2'b00, 2'b00, 2'b00, 2'b00}};
        vecs[6] = '{rst: 1'b0, seed: 8'h00, len: 8'd1, stall: 0, n: 1, c: '{2'b10, 2'b00, 2'b00, 2'b00}};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_color", 32'(color), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(S_IDLE));

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].rst) do_reset();
            do_run(vecs[v].seed, vecs[v].len, vecs[v].stall, 1'b0);
            exp_q.delete();
            for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].c[k]);
            chk($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size(); k++) begin
                if (k < got_q.size())
                    chk($sformatf("vec%0d_color%0d", v, k), 32'(got_q[k]), 32'(exp_q[k]));
            end
        end

        // Reset asserted between edges in the middle of a run.
        do_reset();
        @(negedge clk);
        start = 1'b1;
        seed  = 8'h00;
        len   = 8'd10;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midrun_valid_up", 32'(valid), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_valid", 32'(valid), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_done", 32'(done), 32'd0);
        chk("midrun_rst_state", 32'(dbg_state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        do_run(8'h03, 8'd1, 0, 1'b0);
        chk("post_rst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("post_rst_first_color", 32'(got_q[0]), 32'(C0));

        // Long stream with stray start pulses, checked against the checker rules.
        do_reset();
        do_run(8'h3C, 8'd200, 0, 1'b1);
        chk("long_count", 32'(got_q.size()), 32'd200);
        h = HIST_RST;
        for (int k = 0; k < got_q.size(); k++) begin
            cc = got_q[k];
            ok = 1'b1;
            if (h[3:2] == cc && h[1:0] == cc) ok = 1'b0;
            if (h[1:0] == 2'b00 && cc == 2'b01) ok = 1'b0;
            if (h[1:0] == 2'b01 && cc == 2'b00) ok = 1'b0;
            chk($sformatf("long_legal%0d", k), 32'(ok), 32'd1);
            h = {h[1:0], cc};
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coloring_gen.md
# coloring_gen

Source-side companion to the coloring checker. It emits a stream of 2-bit colors that never breaks the checker's rules: no color three times in a row, and colors 00 and 01 never adjacent. The stream uses a valid/ready handshake, takes its random choices from a seeded LFSR and sends a programmable number of colors per run. Its output drives the checker's `color` input directly, either as self-test stimulus or as a legal-traffic source.

## Interface
- `LEN_W`, 8: width of the run-length input and the internal down-counter.
- `SEED_DEF`, 8'hA5: LFSR value used at reset and whenever `seed` is 0.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. Clears all state immediately.
- `start` in 1: run request; sampled only in IDLE.
- `seed` in 8: LFSR seed, loaded on accepted `start`.
- `len` in LEN_W: number of colors to send this run.
- `ready` in 1: sink accepts the current color.
- `valid` out 1: `color` holds a legal pending color.
- `color` out 2: registered color output.
- `busy` out 1: high in SEND and DONE.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- State machine: IDLE, SEND, DONE.
  - IDLE with `start`=1 and `len`=0: go to DONE; no color is sent.
  - IDLE with `start`=1 and `len`>0:
    - load the LFSR with `seed` (or `SEED_DEF` if `seed` is 0);
    - set `cnt` = `len`;
    - register the first picked color;
    - set `valid`=1 and go to SEND.
  - SEND with `valid`&`ready`:
    - shift `hist` to {`hist[1:0]`, `color`};
    - step the LFSR;
    - if `cnt`==1: clear `valid` and go to DONE;
    - otherwise: decrement `cnt` and register the next picked color. `valid` stays 1.
  - DONE: `done`=1 for one cycle, then go to IDLE.
  - `start` is ignored while `busy`.
- `hist[3:0]` holds {previous-previous, previous} color. It resets to 4'b1111 to match the checker's reset state. Because of this, 11 is illegal as the first color after reset. `hist` persists across runs and is cleared only by `rst_n`.
- Legality rules for a candidate `c`:
  - `c` is illegal if `hist[3:2]`==`hist[1:0]`==`c`;
  - `c` is illegal if {`hist[1:0]`,`c`} is {00,01} or {01,00};
  - at most two values are ever excluded, so a legal color always exists.
- Picking the color:
  - the candidate is `lfsr[1:0]` of the LFSR state before it steps;
  - try `c`, `c`+1, `c`+2, `c`+3 (mod 4) in that order and take the first legal one.
- LFSR: 8-bit Fibonacci, shifts left, new bit 0 = `l[7]`^`l[5]`^`l[4]`^`l[3]`. It steps only on accepted transfers.

## Timing
- Reset values: `valid`=0, `color`=2'b00, `busy`=0, `done`=0. Internal state: `hist`=4'b1111, `lfsr`=`SEED_DEF`, `cnt`=0, state=IDLE.
- `start` sampled at edge N: `valid` and first `color` appear after edge N; `busy` rises the same edge.
- Throughput is one color per cycle while `ready`=1. `valid` stays high between transfers with no bubbles.
- While `valid`&!`ready`, `color` is held stable; `hist`, `lfsr` and `cnt` do not change.
- Last transfer at edge M: `valid` falls and `done`=1 after M, `done` falls after M+1, `busy` falls after M+1.
- `len`=0: `done` pulses the cycle after the start edge; `valid` never rises.
- `rst_n` low mid-run: `valid`, `busy` and `done` go 0 immediately and `hist` returns to 1111. No partial transfer completes.
- `ready` is ignored when `valid`=0.

## Structure
- `coloring_pkg` holds:
  - color constants `C0`..`C3`;
  - the state encoding;
  - `HIST_RST`=4'b1111;
  - the LFSR tap mask;
  - a `legal(hist, c)` function shared with checker testbenches.
- One sub-module, `coloring_pick`: combinational; inputs `hist` and `cand`, output the first legal color in rotation order. It is reused by the checker's bench as a reference model.

## Test plan
- Reset, `seed`=8'h00 (so `SEED_DEF` 8'hA5), `len`=3, `ready`=1 -> colors 01, 10, 01 on consecutive cycles; `done` pulses one cycle after the third transfer.
- Reset, `seed`=8'h03, `len`=1 -> candidate 11 is illegal against `hist` 1111, so `color`=00 is sent.
- `len`=4, `ready` low for 5 cycles after the first `valid` -> `color` is stable throughout; exactly 4 transfers total; LFSR steps only 4 times.
- `len`=0 -> `valid` never asserts; `done` pulses once; `busy` high for exactly 1 cycle.
- `rst_n` pulsed low between clock edges during a `len`=10 run -> `valid` and `busy` drop immediately; the next run after reset starts from `hist` 1111 (first color is never 11).
- Generator feeding the checker, `seed`=8'h3C, `len`=200, `ready`=1 -> checker `check` stays 0 for all 200 colors; `start` pulses during the run have no effect.
